// File: rtl/mmio_led_fifo.sv
// mmio_led_fifo: memory-mapped LED output port.
// CPU stores to DATA_ADDR push bytes into a small FIFO. The FIFO drains to
// LEDR at one byte every DRAIN_CYCLES clocks.
// CPU loads from STAT_ADDR return the FIFO status. Loads from DATA_ADDR
// return the byte currently on the LEDs.
//
// Ports:
//   clk        - system clock, posedge
//   reset      - asynchronous, active-low
//   mem_cmd    - 00 none, 01 write, 10 read, 11 ignored
//   mem_addr   - bus address (9 bits)
//   write_data - store data; only [7:0] is used
//   read_data  - load data; 0 when read_en=0
//   read_en    - this block owns the current load
//   LEDR       - currently displayed byte
module mmio_led_fifo #(
  parameter logic [8:0] DATA_ADDR    = 9'h100,
  parameter logic [8:0] STAT_ADDR    = 9'h101,
  parameter int         DEPTH        = 4,    // 2 or 4
  parameter int         DRAIN_CYCLES = 8     // >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        read_en,
  output logic [7:0]  LEDR
);

  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD  = 2'b10;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DRAIN_CYCLES);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [2:0]    DEPTH_C    = 3'(DEPTH);

  typedef struct packed {
    logic [9:0] rsvd;
    logic       ovf;
    logic       full;
    logic       empty;
    logic [2:0] cnt;
  } stat_t;

  logic [DEPTH-1:0][7:0] mem;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [2:0]            count;
  logic [CW-1:0]         dcnt;
  logic                  ovf;

  logic  push_req, stat_rd, empty, full, pop, push_acc;
  stat_t stat;
  logic  unused_hi;

  assign unused_hi = ^write_data[15:8];

  // Bus decode
  assign push_req = (mem_cmd == MWRITE) && (mem_addr == DATA_ADDR);
  assign stat_rd  = (mem_cmd == MREAD)  && (mem_addr == STAT_ADDR);
  assign read_en  = (mem_cmd == MREAD)  &&
                    ((mem_addr == DATA_ADDR) || (mem_addr == STAT_ADDR));

  assign empty = (count == 3'd0);
  assign full  = (count == DEPTH_C);
  assign pop   = !empty && (dcnt == DRAIN_LAST);
  // A same-edge pop frees the slot, so a push on a full FIFO is still accepted.
  assign push_acc = push_req && (!full || pop);

  always_comb begin
    stat       = '0;
    stat.ovf   = ovf;
    stat.full  = full;
    stat.empty = empty;
    stat.cnt   = count;
  end

  always_comb begin
    read_data = 16'h0000;
    if (read_en)
      read_data = (mem_addr == DATA_ADDR) ? {8'h00, LEDR} : stat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 3'd0;
      dcnt   <= '0;
      ovf    <= 1'b0;
      LEDR   <= 8'h00;
    end else begin
      if (push_acc) begin
        mem[wr_ptr] <= write_data[7:0];
        wr_ptr      <= wr_ptr + PW'(1);
      end
      // LEDR samples the old head even when a push hits the same slot.
      if (pop) begin
        LEDR   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + {2'b00, push_acc} - {2'b00, pop};

      // Drain timer only runs while something is queued.
      if (empty || pop) dcnt <= '0;
      else              dcnt <= dcnt + CW'(1);

      // A status load returns the old flag and clears it on the same edge.
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (stat_rd)             ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_led_fifo.sv
// Directed bench for mmio_led_fifo. Expected values are hand-computed.
module tb_mmio_led_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_en;
  logic [7:0]  LEDR;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_led_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .read_en    (read_en),
    .LEDR       (LEDR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle();
    mem_cmd    = 2'b00;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
  endtask

  task automatic push(input logic [15:0] d);
    mem_cmd = 2'b01; mem_addr = 9'h100; write_data = d;
    tick();
    idle();
  endtask

  // Status load: check combinational data, then let the edge sample it.
  task automatic stat(input string tag, input logic [15:0] exp);
    mem_cmd = 2'b10; mem_addr = 9'h101;
    #1;
    chk({tag, "_en"}, {15'd0, read_en}, 16'd1);
    chk(tag, read_data, exp);
    tick();
    idle();
  endtask

  task automatic iso(input string tag, input logic [1:0] c, input logic [8:0] a);
    mem_cmd = c; mem_addr = a; write_data = 16'h0077;
    #1;
    chk({tag, "_en"}, {15'd0, read_en}, 16'd0);
    chk({tag, "_rd"}, read_data, 16'h0000);
    tick();
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tickn(2);
    chk("rst_led", {8'h00, LEDR}, 16'h0000);
    reset = 1'b1;
    tick();
    #1;
    chk("idle_en", {15'd0, read_en}, 16'd0);
    chk("idle_rd", read_data, 16'h0000);
    stat("rst_stat", 16'h0008);

    // Single push: visible exactly 8 edges later.
    push(16'hAB5A);                 // edge k
    stat("one_stat", 16'h0001);     // edge k+1
    tickn(6);                       // edge k+7
    chk("one_pre", {8'h00, LEDR}, 16'h005A & 16'h0000);
    tick();                         // edge k+8
    chk("one_led", {8'h00, LEDR}, 16'h005A);

    // Fill, overflow, clear-on-read, then a push on the full-pop edge.
    push(16'h0001);                 // edge k
    push(16'h0002);
    push(16'h0003);
    push(16'h0004);
    push(16'h0005);                 // edge k+4: dropped
    stat("ovf_stat1", 16'h0034);    // edge k+5
    stat("ovf_stat2", 16'h0014);    // edge k+6
    tick();                         // edge k+7
    chk("fill_pre", {8'h00, LEDR}, 16'h005A);
    push(16'h00EE);                 // edge k+8: pop and push together
    chk("fill_01", {8'h00, LEDR}, 16'h0001);
    stat("popush_stat", 16'h0014);  // edge k+9
    tickn(6);                       // edge k+15
    chk("fill_hold", {8'h00, LEDR}, 16'h0001);
    tick();
    chk("fill_02", {8'h00, LEDR}, 16'h0002);
    tickn(8);
    chk("fill_03", {8'h00, LEDR}, 16'h0003);
    tickn(8);
    chk("fill_04", {8'h00, LEDR}, 16'h0004);
    tickn(8);
    chk("fill_ee", {8'h00, LEDR}, 16'h00EE);
    tickn(8);
    chk("fill_end", {8'h00, LEDR}, 16'h00EE);
    stat("fill_stat", 16'h0008);

    // Decode isolation.
    iso("iso_w0ff", 2'b01, 9'h0FF);
    iso("iso_w101", 2'b01, 9'h101);
    iso("iso_r102", 2'b10, 9'h102);
    iso("iso_c3",   2'b11, 9'h100);
    stat("iso_stat", 16'h0008);
    tickn(10);
    chk("iso_led", {8'h00, LEDR}, 16'h00EE);

    // LED readback.
    push(16'h003C);
    tickn(7);
    chk("dr_pre", {8'h00, LEDR}, 16'h00EE);
    tick();
    chk("dr_led", {8'h00, LEDR}, 16'h003C);
    mem_cmd = 2'b10; mem_addr = 9'h100;
    #1;
    chk("dr_en", {15'd0, read_en}, 16'd1);
    chk("dr_rd", read_data, 16'h003C);
    tick();
    idle();
    stat("dr_stat", 16'h0008);

    // Reset mid-drain with 3 queued bytes.
    push(16'h0011);
    push(16'h0022);
    push(16'h0033);
    tickn(3);
    reset = 1'b0;
    #2;
    chk("rst2_led", {8'h00, LEDR}, 16'h0000);
    tick();
    reset = 1'b1;
    tick();
    stat("rst2_stat", 16'h0008);
    tickn(20);
    chk("rst2_hold", {8'h00, LEDR}, 16'h0000);
    stat("rst2_stat2", 16'h0008);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
